// File: rtl/clint_trap_seq.sv
// clint_trap_seq: machine-mode trap/return sequencer.
// Serialises mepc/mcause/mstatus writes, then redirects fetch.
module clint_trap_seq #(
  parameter logic [11:0] ADDR_MSTATUS  = 12'h300,
  parameter logic [11:0] ADDR_MEPC     = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE   = 12'h342,
  parameter logic [31:0] CAUSE_ECALL   = 32'h0000000B,
  parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_id,
  input  logic        mret_id,
  input  logic        irq_ext,
  input  logic [31:0] inst_pc_id,
  input  logic        csr_we_ex,
  input  logic        interrupt_enable,
  input  logic [31:0] clint_csr_mstatus,
  input  logic [31:0] clint_csr_mepc,
  input  logic [31:0] clint_csr_mtvec,
  output logic        we_clint,
  output logic [11:0] wa_clint,
  output logic [31:0] wd_clint,
  output logic        hold_pipe,
  output logic        jump_flag,
  output logic [31:0] jump_addr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MSTATUS,
    R_MSTATUS,
    JUMP
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic        ret_q;

  logic take_ecall;
  logic take_mret;
  logic take_irq;
  logic accept;
  logic [31:0] ms_trap;
  logic [31:0] ms_ret;

  assign take_ecall = ecall_id;
  assign take_mret  = !ecall_id && mret_id;
  assign take_irq   = !ecall_id && !mret_id
                   && irq_ext && interrupt_enable;
  assign accept     = (state == IDLE)
                   && (take_ecall || take_mret || take_irq);

  // MPIE <- MIE, MIE <- 0 on trap entry
  assign ms_trap = {clint_csr_mstatus[31:8],
                    clint_csr_mstatus[3],
                    clint_csr_mstatus[6:4],
                    1'b0,
                    clint_csr_mstatus[2:0]};

  // MIE <- MPIE, MPIE <- 1 on return
  assign ms_ret  = {clint_csr_mstatus[31:8],
                    1'b1,
                    clint_csr_mstatus[6:4],
                    clint_csr_mstatus[7],
                    clint_csr_mstatus[2:0]};

  // sequencer state; write states stall while EX owns the port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      ret_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            take_ecall: begin
              pc_q    <= inst_pc_id;
              cause_q <= CAUSE_ECALL;
              ret_q   <= 1'b0;
              state   <= T_MEPC;
            end
            take_mret: begin
              ret_q <= 1'b1;
              state <= R_MSTATUS;
            end
            take_irq: begin
              pc_q    <= inst_pc_id;
              cause_q <= CAUSE_EXT_IRQ;
              ret_q   <= 1'b0;
              state   <= T_MEPC;
            end
            default: state <= IDLE;
          endcase
        end
        T_MEPC: begin
          if (!csr_we_ex) state <= T_MCAUSE;
        end
        T_MCAUSE: begin
          if (!csr_we_ex) state <= T_MSTATUS;
        end
        T_MSTATUS: begin
          if (!csr_we_ex) state <= JUMP;
        end
        R_MSTATUS: begin
          if (!csr_we_ex) state <= JUMP;
        end
        JUMP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore write/redirect outputs decoded from state
  always_comb begin
    we_clint  = 1'b0;
    wa_clint  = '0;
    wd_clint  = '0;
    jump_flag = 1'b0;
    jump_addr = '0;
    unique case (state)
      T_MEPC: begin
        we_clint = 1'b1;
        wa_clint = ADDR_MEPC;
        wd_clint = pc_q;
      end
      T_MCAUSE: begin
        we_clint = 1'b1;
        wa_clint = ADDR_MCAUSE;
        wd_clint = cause_q;
      end
      T_MSTATUS: begin
        we_clint = 1'b1;
        wa_clint = ADDR_MSTATUS;
        wd_clint = ms_trap;
      end
      R_MSTATUS: begin
        we_clint = 1'b1;
        wa_clint = ADDR_MSTATUS;
        wd_clint = ms_ret;
      end
      JUMP: begin
        jump_flag = 1'b1;
        if (ret_q) jump_addr = clint_csr_mepc;
        else jump_addr = clint_csr_mtvec & 32'hFFFF_FFFC;
      end
      default: begin
        we_clint = 1'b0;
      end
    endcase
  end

  // stall on acceptance and for the whole sequence
  always_comb begin
    busy      = (state != IDLE);
    hold_pipe = busy || (accept && !rst);
  end

endmodule

// File: tb/tb_clint_trap_seq.sv
// tb_clint_trap_seq: directed + random check of the sequencer
// against a queue-of-pending-actions model and a small CSR file.
module tb_clint_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_id;
  logic        mret_id;
  logic        irq_ext;
  logic [31:0] inst_pc_id;
  logic        csr_we_ex;
  logic [31:0] csr_mstatus;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mcause;
  logic [31:0] csr_mtvec;
  logic        we_clint;
  logic [11:0] wa_clint;
  logic [31:0] wd_clint;
  logic        hold_pipe;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        busy;
  logic [11:0] ex_wa;
  logic [31:0] ex_wd;

  always #5 clk = ~clk;

  clint_trap_seq dut (
    .clk               (clk),
    .rst               (rst),
    .ecall_id          (ecall_id),
    .mret_id           (mret_id),
    .irq_ext           (irq_ext),
    .inst_pc_id        (inst_pc_id),
    .csr_we_ex         (csr_we_ex),
    .interrupt_enable  (csr_mstatus[3]),
    .clint_csr_mstatus (csr_mstatus),
    .clint_csr_mepc    (csr_mepc),
    .clint_csr_mtvec   (csr_mtvec),
    .we_clint          (we_clint),
    .wa_clint          (wa_clint),
    .wd_clint          (wd_clint),
    .hold_pipe         (hold_pipe),
    .jump_flag         (jump_flag),
    .jump_addr         (jump_addr),
    .busy              (busy)
  );

  localparam int K_WR  = 0;
  localparam int K_TMS = 1;
  localparam int K_RMS = 2;
  localparam int K_JT  = 3;
  localparam int K_JR  = 4;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] val;
  } op_t;

  op_t q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  int          last_lat = -1;
  int          n_jumps = 0;
  int          j0;
  logic [31:0] last_ja = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] trap_ms(input logic [31:0] ms);
    return (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] ret_ms(input logic [31:0] ms);
    return (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
  endfunction

  task automatic csr_write(input logic [11:0] a,
                           input logic [31:0] d);
    case (a)
      12'h300: csr_mstatus = d;
      12'h341: csr_mepc    = d;
      12'h342: csr_mcause  = d;
      default: ;
    endcase
  endtask

  task automatic push_trap(input logic [31:0] pc,
                           input logic [31:0] cause);
    q.push_back('{K_WR, 12'h341, pc});
    q.push_back('{K_WR, 12'h342, cause});
    q.push_back('{K_TMS, 12'h300, 32'h0});
    q.push_back('{K_JT, 12'h000, 32'h0});
  endtask

  task automatic step(input logic r, input logic e,
                      input logic m, input logic i,
                      input logic [31:0] pc, input logic ex);
    logic        ew, eh, ej, eb, acc;
    logic [11:0] ea;
    logic [31:0] ed, eja;
    logic        d_we;
    logic [11:0] d_wa;
    logic [31:0] d_wd;
    op_t         h;
    @(negedge clk);
    rst = r; ecall_id = e; mret_id = m;
    irq_ext = i; inst_pc_id = pc; csr_we_ex = ex;
    #1;
    ew = 0; ea = '0; ed = '0; eh = 0;
    ej = 0; eja = '0; eb = 0; acc = 0;
    h = '{K_WR, 12'h0, 32'h0};
    if (r) begin
      q.delete();
    end else if (q.size() > 0) begin
      h = q[0];
      eb = 1; eh = 1;
      case (h.kind)
        K_WR:  begin ew = 1; ea = h.addr; ed = h.val; end
        K_TMS: begin
          ew = 1; ea = 12'h300; ed = trap_ms(csr_mstatus);
        end
        K_RMS: begin
          ew = 1; ea = 12'h300; ed = ret_ms(csr_mstatus);
        end
        K_JT:  begin ej = 1; eja = csr_mtvec & ~32'h3; end
        default: begin ej = 1; eja = csr_mepc; end
      endcase
    end else if (e || m || (i && csr_mstatus[3])) begin
      eh = 1; acc = 1;
    end
    chk("we_clint", {31'b0, we_clint}, {31'b0, ew});
    chk("wa_clint", {20'b0, wa_clint}, {20'b0, ea});
    chk("wd_clint", wd_clint, ed);
    chk("hold_pipe", {31'b0, hold_pipe}, {31'b0, eh});
    chk("jump_flag", {31'b0, jump_flag}, {31'b0, ej});
    chk("jump_addr", jump_addr, eja);
    chk("busy", {31'b0, busy}, {31'b0, eb});
    if (jump_flag === 1'b1) begin
      n_jumps++;
      last_lat = cyc - acc_cyc;
      last_ja  = jump_addr;
    end
    d_we = we_clint; d_wa = wa_clint; d_wd = wd_clint;
    @(posedge clk);
    #1;
    if (ex) csr_write(ex_wa, ex_wd);
    else if (d_we === 1'b1) csr_write(d_wa, d_wd);
    if (!r) begin
      if (q.size() > 0) begin
        if (h.kind >= K_JT || !ex) void'(q.pop_front());
      end else if (acc) begin
        acc_cyc = cyc;
        if (e) push_trap(pc, 32'h0000000B);
        else if (m) begin
          q.push_back('{K_RMS, 12'h300, 32'h0});
          q.push_back('{K_JR, 12'h000, 32'h0});
        end else push_trap(pc, 32'h8000000B);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    rst = 1; ecall_id = 0; mret_id = 0; irq_ext = 0;
    inst_pc_id = '0; csr_we_ex = 0;
    csr_mstatus = '0; csr_mepc = '0;
    csr_mcause = '0; csr_mtvec = '0;
    ex_wa = 12'h340; ex_wd = '0;
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 1, 0, 0, 32'h40, 0);
    idle(1);

    csr_mstatus = 32'h8; csr_mtvec = 32'h201;
    step(0, 1, 0, 0, 32'h100, 0);
    idle(6);
    chk("ecall_mepc", csr_mepc, 32'h100);
    chk("ecall_mcause", csr_mcause, 32'hB);
    chk("ecall_mstatus", csr_mstatus, 32'h80);
    chk("ecall_lat", last_lat, 4);
    chk("ecall_target", last_ja, 32'h200);

    csr_mstatus = 32'h0;
    j0 = n_jumps;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 32'h200, 0);
    chk("irq_masked", n_jumps, j0);
    csr_mstatus = 32'h8;
    for (int k = 0; k < 7; k++) step(0, 0, 0, 1, 32'h300, 0);
    chk("irq_mcause", csr_mcause, 32'h8000000B);
    chk("irq_mepc", csr_mepc, 32'h300);
    chk("irq_jumps", n_jumps, j0 + 1);

    csr_mstatus = 32'h80; csr_mepc = 32'h104;
    step(0, 0, 1, 0, 32'h0, 0);
    idle(4);
    chk("mret_mstatus", csr_mstatus, 32'h88);
    chk("mret_lat", last_lat, 2);
    chk("mret_target", last_ja, 32'h104);

    csr_mstatus = 32'h8;
    step(0, 1, 0, 0, 32'h180, 0);
    idle(1);
    step(0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 1);
    idle(6);
    chk("conf_lat", last_lat, 6);
    chk("conf_mepc", csr_mepc, 32'h180);
    chk("conf_mcause", csr_mcause, 32'hB);
    chk("conf_mstatus", csr_mstatus, 32'h80);

    csr_mstatus = 32'h8;
    j0 = n_jumps;
    step(0, 1, 0, 1, 32'h240, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 1, 32'h240, 0);
    chk("both_mcause", csr_mcause, 32'hB);
    chk("both_jumps", n_jumps, j0 + 1);
    chk("both_mstatus", csr_mstatus, 32'h80);

    csr_mstatus = 32'h8; csr_mcause = 32'h55;
    step(0, 1, 0, 0, 32'h2C0, 0);
    idle(1);
    step(1, 0, 0, 0, 32'h0, 0);
    idle(3);
    chk("rst_mepc_kept", csr_mepc, 32'h2C0);
    chk("rst_mcause", csr_mcause, 32'h55);

    for (int k = 0; k < 600; k++) begin
      logic rr, ee, mm, ii, xx;
      rr = ($urandom % 64) == 0;
      ee = ($urandom % 8) == 0;
      mm = ($urandom % 8) == 0;
      ii = ($urandom % 3) == 0;
      xx = ($urandom % 4) == 0;
      case ($urandom % 3)
        0: ex_wa = 12'h300;
        1: ex_wa = 12'h341;
        default: ex_wa = 12'h340;
      endcase
      ex_wd = $urandom;
      if (($urandom % 16) == 0) csr_mtvec = $urandom;
      step(rr, ee, mm, ii, $urandom & 32'hFFFF_FFFC, xx);
    end
    ex_wa = 12'h340;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clint_trap_seq.md
Name: clint_trap_seq

Overview:
- Trap/return sequencer for the machine-mode CSR register file.
- On ecall, mret or an enabled external interrupt, it stalls the pipeline and issues an ordered series of single-cycle writes on the CSR file's CLINT write port (mepc, mcause, mstatus).
- It then redirects fetch to the trap vector or to mepc.
- It shares the CSR write port with the EX stage; the CSR file always gives EX priority, and this block defers its own write while EX is writing.

Parameters:
- ADDR_MSTATUS, 12'h300, CSR address of mstatus
- ADDR_MEPC, 12'h341, CSR address of mepc
- ADDR_MCAUSE, 12'h342, CSR address of mcause
- CAUSE_ECALL, 32'h0000000B, mcause written for ecall from M-mode
- CAUSE_EXT_IRQ, 32'h8000000B, mcause written for machine external interrupt

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- ecall_id  input  1  ecall decoded in ID this cycle
- mret_id  input  1  mret decoded in ID this cycle
- irq_ext  input  1  level-sensitive external interrupt request
- inst_pc_id  input  32  PC of the instruction currently in ID
- csr_we_ex  input  1  EX-stage CSR write active (wins the write port)
- interrupt_enable  input  1  mstatus.MIE from the CSR file
- clint_csr_mstatus  input  32  live mstatus
- clint_csr_mepc  input  32  live mepc
- clint_csr_mtvec  input  32  live mtvec
- we_clint  output  1  CSR write enable
- wa_clint  output  12  CSR write address
- wd_clint  output  32  CSR write data
- hold_pipe  output  1  stall IF/ID, bubble into EX
- jump_flag  output  1  one-cycle fetch redirect
- jump_addr  output  32  redirect target
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; captured PC and cause registers are cleared to 0.
  - All outputs are 0 while rst is high and on release.
  - Reset mid-sequence abandons the sequence immediately. CSR writes already committed are not undone.
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, R_MSTATUS, JUMP.
- Acceptance in IDLE, in priority order ecall_id > mret_id > (irq_ext & interrupt_enable):
  - ecall: capture pc_q=inst_pc_id, cause_q=CAUSE_ECALL, then go to T_MEPC.
  - irq: capture pc_q=inst_pc_id (the ID instruction has not executed), cause_q=CAUSE_EXT_IRQ, then go to T_MEPC.
  - mret: go to R_MSTATUS.
  - Simultaneous ecall and irq: ecall wins. The irq stays pending and is masked afterwards because MIE=0.
- hold_pipe:
  - Combinational: 1 in the IDLE cycle where a request is accepted.
  - 1 in every non-IDLE state.
  - 0 otherwise.
- Write states (Moore outputs, we_clint=1):
  - T_MEPC: wa=ADDR_MEPC, wd=pc_q.
  - T_MCAUSE: wa=ADDR_MCAUSE, wd=cause_q.
  - T_MSTATUS: wa=ADDR_MSTATUS, wd = live mstatus with bit7(MPIE)=bit3(MIE) and bit3=0; all other bits are passed through.
  - R_MSTATUS: wa=ADDR_MSTATUS, wd = live mstatus with bit3=bit7 and bit7=1.
  - Port conflict: if csr_we_ex=1 in a write state, the state does not advance and the outputs stay asserted, so the write retries next cycle. wd is recomputed from live mstatus, which picks up the older EX write.
- Transitions:
  - T_MEPC→T_MCAUSE→T_MSTATUS→JUMP
  - R_MSTATUS→JUMP
  - JUMP→IDLE unconditionally
- JUMP:
  - we_clint=0, jump_flag=1 for exactly one cycle.
  - Trap path: jump_addr={clint_csr_mtvec[31:2],2'b00}. Direct mode only; the mtvec mode bits are ignored.
  - mret path: jump_addr=clint_csr_mepc.
  - A path flag is registered at acceptance to select the target.
  - jump_addr is 0 outside JUMP.
- Latency with no conflicts:
  - Trap: accept at cycle N, jump_flag at cycle N+4.
  - mret: accept at cycle N, jump_flag at cycle N+2.
- While busy, ecall_id, mret_id and irq_ext are ignored. The irq is level-sensitive and is resampled in IDLE.
- A new request may be accepted in the first IDLE cycle after JUMP.
- When idle: we_clint=0, wa_clint=0, wd_clint=0.

Test Plan:
- Reset, then ecall_id=1 with inst_pc_id=32'h0000_0100, mstatus=32'h8, mtvec=32'h0000_0201:
  - writes mepc=0x100, mcause=0xB, mstatus=0x80 on consecutive cycles.
  - jump_flag at N+4 with jump_addr=0x200.
  - hold_pipe high N..N+4.
- irq_ext=1 with interrupt_enable=0 -> no activity. Raise interrupt_enable -> mcause=0x8000000B and mepc=inst_pc_id.
- mret with mstatus=0x80, mepc=0x104 -> writes mstatus=0x88, then jump_flag at N+2 with jump_addr=0x104.
- csr_we_ex=1 for 2 cycles during T_MCAUSE -> T_MCAUSE held 2 extra cycles with we_clint=1, jump_flag at N+6, final CSR values correct.
- ecall_id and irq_ext (enabled) together -> mcause=0xB. No second trap afterwards, because MIE=0.
- rst pulsed while in T_MCAUSE -> all outputs 0 immediately, FSM in IDLE. The mepc written before the reset pulse is retained by the CSR file.
